cla_response_checker: RTL

- Consumes the (A, B, Cin, S, Cout) sample stream that a stimulus driver applies to a WIDTH-bit carry look-ahead adder.
- Recomputes the golden sum for each sample and compares it with the DUT result.
- Keeps saturating pass/fail counts, captures the first mismatch, and reports an end-of-test verdict.
- Synthesizable, so the same block serves as a bench scoreboard or as on-chip BIST for the adder family.

---
 rtl/cla_response_checker_pkg.sv | 22 ++
 rtl/cla_response_checker_if.sv | 13 +
 rtl/cla_response_checker_golden_add.sv | 11 +
 rtl/cla_response_checker.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/cla_response_checker_pkg.sv
// Shared types for the CLA response checker: FSM states, default widths, sample record.
package cla_chk_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } chk_state_t;

  typedef struct packed {
    logic [DEF_WIDTH-1:0] a;
    logic [DEF_WIDTH-1:0] b;
    logic                 cin;
    logic [DEF_WIDTH-1:0] s;
    logic                 cout;
  } sample_t;

endpackage

// File: rtl/cla_response_checker_if.sv
// Sample stream from the adder stimulus driver into the checker; valid/ready handshake.
interface cla_response_checker_if #(parameter int WIDTH = 4);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [WIDTH-1:0] s;
  logic             cout;

  modport master (output in_valid, a, b, cin, s, cout, input in_ready);
  modport slave  (input in_valid, a, b, cin, s, cout, output in_ready);
endinterface

// File: rtl/cla_response_checker_golden_add.sv
// Combinational reference adder, full WIDTH+1-bit result; zero latency, no backpressure.
module cla_golden_add #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH:0]   sum
);
  assign sum = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
endmodule

// File: rtl/cla_response_checker.sv
// Scoreboard for a WIDTH-bit CLA: counters/first-error update 2 edges after acceptance.
// in_ready only in RUN; optional idle watchdog under CLA_CHK_TIMEOUT_EN.
module cla_response_checker
  import cla_chk_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 finish,
  cla_response_checker_if.slave smp,
  output logic [CNT_W-1:0]     pass_cnt,
  output logic [CNT_W-1:0]     fail_cnt,
  output logic                 err_valid,
  output logic [WIDTH-1:0]     err_a,
  output logic [WIDTH-1:0]     err_b,
  output logic                 err_cin,
  output logic [WIDTH:0]       err_got,
  output logic [WIDTH:0]       err_exp,
  output logic                 done,
  output logic                 all_pass,
  output logic                 timeout
);

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [WIDTH:0]   got;
    logic [WIDTH:0]   exp;
  } stg_t;

  chk_state_t     state_q, state_d;
  logic           in_ready;
  logic           accept;
  logic           clr;
  logic           timeout_hit;
  logic [WIDTH:0] exp_sum;
  logic           stg_vld;
  stg_t           stg;

  cla_golden_add #(.WIDTH(WIDTH)) u_gold (
    .a   (smp.a),
    .b   (smp.b),
    .cin (smp.cin),
    .sum (exp_sum)
  );

  assign smp.in_ready = in_ready;
  assign accept       = smp.in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (finish || timeout_hit) state_d = FLUSH;
      FLUSH:   state_d = DONE;
      DONE:    if (start) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state_q == RUN);
    done     = (state_q == DONE);
    clr      = start && ((state_q == IDLE) || (state_q == DONE));
  end

  assign all_pass = done && (fail_cnt == '0) && (pass_cnt != '0) && !timeout;

  // Stage register holds one accepted sample; it retires on the following edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_vld   <= 1'b0;
      stg       <= '0;
      pass_cnt  <= '0;
      fail_cnt  <= '0;
      err_valid <= 1'b0;
      err_a     <= '0;
      err_b     <= '0;
      err_cin   <= 1'b0;
      err_got   <= '0;
      err_exp   <= '0;
    end else begin
      stg_vld <= accept;
      if (accept) begin
        stg.a   <= smp.a;
        stg.b   <= smp.b;
        stg.cin <= smp.cin;
        stg.got <= {smp.cout, smp.s};
        stg.exp <= exp_sum;
      end
      if (clr) begin
        pass_cnt  <= '0;
        fail_cnt  <= '0;
        err_valid <= 1'b0;
      end else if (stg_vld) begin
        if (stg.got == stg.exp) begin
          if (pass_cnt != '1) pass_cnt <= pass_cnt + 1'b1;
        end else begin
          if (fail_cnt != '1) fail_cnt <= fail_cnt + 1'b1;
          if (!err_valid) begin
            err_valid <= 1'b1;
            err_a     <= stg.a;
            err_b     <= stg.b;
            err_cin   <= stg.cin;
            err_got   <= stg.got;
            err_exp   <= stg.exp;
          end
        end
      end
    end
  end

`ifdef CLA_CHK_TIMEOUT_EN
  localparam int IDLE_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic [IDLE_W-1:0] idle_q;

  assign timeout_hit = (state_q == RUN) && (idle_q == IDLE_W'(TIMEOUT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_q  <= '0;
      timeout <= 1'b0;
    end else begin
      if (clr || accept)        idle_q <= '0;
      else if (state_q == RUN)  idle_q <= idle_q + 1'b1;
      if (clr)              timeout <= 1'b0;
      else if (timeout_hit) timeout <= 1'b1;
    end
  end
`else
  logic timeout_unused;
  assign timeout_unused = (TIMEOUT != 0);
  assign timeout_hit    = 1'b0;
  assign timeout        = 1'b0;
`endif

endmodule
